// File: rtl/digilock_pkg.sv
// Shared DigiLock definitions: keypad scanner states, row drive patterns and
// helpers for decoding the synchronised column pattern.
package digilock_pkg;

  localparam int unsigned LARG_TECLA = 4;

  localparam logic [3:0] LINHA0         = 4'b1110;
  localparam logic [3:0] LINHA1         = 4'b1101;
  localparam logic [3:0] LINHA2         = 4'b1011;
  localparam logic [3:0] LINHA3         = 4'b0111;
  localparam logic [3:0] COLUNAS_SOLTAS = 4'b1111;

  typedef enum logic [1:0] {
    VARRE,
    ESTABILIZA,
    EMITE,
    SOLTA
  } estado_t;

  function automatic logic [3:0] padrao_linha(input logic [1:0] idx);
    logic [3:0] padrao;
    case (idx)
      2'd0:    padrao = LINHA0;
      2'd1:    padrao = LINHA1;
      2'd2:    padrao = LINHA2;
      default: padrao = LINHA3;
    endcase
    return padrao;
  endfunction

  // True when exactly one column is pulled low; two or more is ghosting.
  function automatic logic um_zero(input logic [3:0] col);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!col[i]) n++;
    end
    return (n == 1);
  endfunction

  function automatic logic [1:0] indice_coluna(input logic [3:0] col);
    logic [1:0] idx;
    case (col)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/sincronizador_colunas.sv
// Two-flop synchroniser for the asynchronous keypad columns; resets to
// all-ones so an idle (pulled-up) keypad is seen during and after reset.
module sincronizador_colunas #(
  parameter int unsigned LARGURA = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [LARGURA-1:0] i_dado,
  output logic [LARGURA-1:0] o_dado
);

  logic [LARGURA-1:0] r_meta;
  logic [LARGURA-1:0] r_sinc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '1;
      r_sinc <= '1;
    end else begin
      r_meta <= i_dado;
      r_sinc <= r_meta;
    end
  end

  assign o_dado = r_sinc;

endmodule

// File: rtl/varredor_teclado.sv
// 4x4 keypad scanner/debouncer: drives one row low at a time, debounces press
// and release, and emits one key code strobe per clean press.
module varredor_teclado
  import digilock_pkg::*;
#(
  parameter int unsigned T_VARREDURA = 4,
  parameter int unsigned T_DEBOUNCE  = 16,
  parameter int unsigned LARG_CONT   = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [3:0]            colunas,
  output logic [3:0]            linhas,
  output logic [LARG_TECLA-1:0] tecla,
  output logic                  tecla_ativada
);

  localparam logic [LARG_CONT-1:0] C_VARR_FIM = LARG_CONT'(T_VARREDURA - 1);
  localparam logic [LARG_CONT-1:0] C_DEB_FIM  = LARG_CONT'(T_DEBOUNCE - 1);

  estado_t                 r_estado;
  logic [LARG_CONT-1:0]    r_cont;
  logic [1:0]              r_idx_linha;
  logic [1:0]              r_idx_coluna;
  logic [3:0]              r_padrao;
  logic [LARG_TECLA-1:0]   r_tecla;
  logic                    r_ativada;

  estado_t                 w_estado_prox;
  logic [LARG_CONT-1:0]    w_cont_prox;
  logic [1:0]              w_idx_linha_prox;
  logic                    w_capturar;
  logic                    w_emitir;
  logic [3:0]              w_col_s;

  sincronizador_colunas #(
    .LARGURA (4)
  ) u_sinc (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_dado  (colunas),
    .o_dado  (w_col_s)
  );

  always_comb begin
    w_estado_prox    = r_estado;
    w_cont_prox      = r_cont + 1'b1;
    w_idx_linha_prox = r_idx_linha;
    w_capturar       = 1'b0;
    w_emitir         = 1'b0;
    case (r_estado)
      VARRE: begin
        if (r_cont == C_VARR_FIM) begin
          w_cont_prox = '0;
          if (um_zero(w_col_s)) begin
            w_capturar    = 1'b1;
            w_estado_prox = ESTABILIZA;
          end else begin
            w_idx_linha_prox = r_idx_linha + 2'd1;
          end
        end
      end
      ESTABILIZA: begin
        if (w_col_s != r_padrao) begin
          w_cont_prox      = '0;
          w_idx_linha_prox = r_idx_linha + 2'd1;
          w_estado_prox    = VARRE;
        end else if (r_cont == C_DEB_FIM) begin
          w_cont_prox   = '0;
          w_emitir      = 1'b1;
          w_estado_prox = EMITE;
        end
      end
      EMITE: begin
        w_cont_prox   = '0;
        w_estado_prox = SOLTA;
      end
      SOLTA: begin
        if (w_col_s != COLUNAS_SOLTAS) begin
          w_cont_prox = '0;
        end else if (r_cont == C_DEB_FIM) begin
          w_cont_prox      = '0;
          w_idx_linha_prox = r_idx_linha + 2'd1;
          w_estado_prox    = VARRE;
        end
      end
      default: begin
        w_cont_prox   = '0;
        w_estado_prox = VARRE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_estado    <= VARRE;
      r_cont      <= '0;
      r_idx_linha <= 2'd0;
    end else begin
      r_estado    <= w_estado_prox;
      r_cont      <= w_cont_prox;
      r_idx_linha <= w_idx_linha_prox;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx_coluna <= 2'd0;
      r_padrao     <= COLUNAS_SOLTAS;
    end else if (w_capturar) begin
      r_idx_coluna <= indice_coluna(w_col_s);
      r_padrao     <= w_col_s;
    end
  end

  // Code and strobe are loaded on the transition into EMITE so that both are
  // presented during the single EMITE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tecla   <= '0;
      r_ativada <= 1'b0;
    end else begin
      r_ativada <= w_emitir;
      if (w_emitir) r_tecla <= {r_idx_linha, r_idx_coluna};
    end
  end

  assign linhas        = padrao_linha(r_idx_linha);
  assign tecla         = r_tecla;
  assign tecla_ativada = r_ativada;

endmodule

// File: tb/tb_varredor_teclado.sv
// Bench for varredor_teclado: keypad matrix model, scan-schedule reference
// model, and a scoreboard monitor that checks every key strobe.
module tb_varredor_teclado;
  import digilock_pkg::*;

  localparam int TV = 4;
  localparam int TD = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] colunas;
  logic [3:0] linhas;
  logic [3:0] tecla;
  logic       tecla_ativada;

  logic [3:0] teclas [4];

  int gcyc = 0;
  int n_checks = 0;
  int n_erros = 0;
  int n_emitidos = 0;
  int n_esperados = 0;
  int ult_strobe = -1;
  int base_b = 0;
  int base_r = 0;

  typedef struct {
    logic [3:0] codigo;
    int         cedo;
    int         tarde;
  } esperado_t;

  esperado_t fila[$];

  varredor_teclado #(
    .T_VARREDURA (TV),
    .T_DEBOUNCE  (TD),
    .LARG_CONT   (8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .colunas       (colunas),
    .linhas        (linhas),
    .tecla         (tecla),
    .tecla_ativada (tecla_ativada)
  );

  always #5 clk = ~clk;

  always @(posedge clk) gcyc <= gcyc + 1;

  always_comb begin
    colunas = '1;
    for (int r = 0; r < 4; r++) begin
      if (!linhas[r]) colunas = colunas & ~teclas[r];
    end
  end

  task automatic chk(input string nome, input int atual, input int esperado);
    n_checks++;
    if (atual != esperado) begin
      n_erros++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nome, atual, esperado, gcyc);
    end
  endtask

  // Idle scan: row (base_r + j) is driven for TV cycles starting at base_b + TV*j.
  function automatic logic [3:0] linha_esperada(input int k);
    logic [3:0] um;
    um = 4'b0001;
    return ~(um << ((base_r + (k - base_b) / TV) % 4));
  endfunction

  // A key visible from cycle p is caught by the first sample of its row whose
  // synchronised data (two cycles old) already includes it.
  function automatic int instante_strobe(input int r, input int p);
    for (int j = 0; j < 100; j++) begin
      if ((base_r + j) % 4 == r && base_b + TV * j + TV - 3 >= p)
        return base_b + TV * j + TV - 1 + TD + 1;
    end
    return -1;
  endfunction

  task automatic esperar_ate(input int k);
    while (gcyc < k) @(negedge clk);
  endtask

  task automatic esperar(input logic [3:0] codigo, input int cedo, input int tarde);
    esperado_t e;
    e.codigo = codigo;
    e.cedo   = cedo;
    e.tarde  = tarde;
    fila.push_back(e);
    n_esperados++;
  endtask

  task automatic soltar(input int r);
    for (int i = 0; i < 4; i++) teclas[i] = 4'b0000;
    base_b = gcyc + TD + 2;
    base_r = (r + 1) % 4;
  endtask

  task automatic checa_reset(input string nome);
    chk({nome, "_linhas"}, int'(linhas), int'(LINHA0));
    chk({nome, "_tecla"}, int'(tecla), 0);
    chk({nome, "_ativada"}, int'(tecla_ativada), 0);
  endtask

  task automatic solta_reset();
    @(negedge clk);
    reset_n = 1'b1;
    base_b  = gcyc;
    base_r  = 0;
  endtask

  always @(negedge clk) begin
    if (tecla_ativada === 1'b1) begin
      n_emitidos++;
      if (ult_strobe >= 0) begin
        n_checks++;
        if (gcyc - ult_strobe < 2 * TD + TV) begin
          n_erros++;
          $display("FAIL strobe_gap: got %0d cycles, required >= %0d", gcyc - ult_strobe, 2 * TD + TV);
        end
      end
      ult_strobe = gcyc;
      if (fila.size() == 0) begin
        n_checks++;
        n_erros++;
        $display("FAIL unexpected_strobe: got tecla=%h at cycle %0d, expected no strobe", tecla, gcyc);
      end else begin
        esperado_t e;
        e = fila.pop_front();
        chk("tecla_code", int'(tecla), int'(e.codigo));
        n_checks++;
        if (gcyc < e.cedo || gcyc > e.tarde) begin
          n_erros++;
          $display("FAIL strobe_time: got cycle %0d, expected %0d..%0d", gcyc, e.cedo, e.tarde);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p, p2, e1, e2, pst, r, c;
    logic [1:0] r2, c2;
    for (int i = 0; i < 4; i++) teclas[i] = 4'b0000;

    // Reset state, then idle scan with no key.
    repeat (3) @(negedge clk);
    checa_reset("reset_inicial");
    solta_reset();
    for (int k = 0; k < 200; k++) begin
      chk("varredura_idle", int'(linhas), int'(linha_esperada(gcyc)));
      @(negedge clk);
    end

    // Clean press row 2 col 1 held 100 cycles.
    p = gcyc;
    teclas[2][1] = 1'b1;
    e1 = instante_strobe(2, p);
    esperar(4'h9, e1, e1);
    esperar_ate(p + 100);
    chk("linha_retida", int'(linhas), int'(LINHA2));
    p2 = gcyc;
    soltar(2);
    esperar_ate(p2 + TD + 1);
    chk("linha_ate_soltar", int'(linhas), int'(LINHA2));
    @(negedge clk);
    chk("linha_apos_soltar", int'(linhas), int'(LINHA3));

    // Bounce on row 0 col 3, then stable.
    esperar_ate(base_b);
    for (int ph = 0; ph < 8; ph++) begin
      teclas[0][3] = (ph % 2 == 0);
      repeat (5) @(negedge clk);
    end
    pst = gcyc;
    teclas[0][3] = 1'b1;
    esperar(4'h3, pst + TD + 3, pst + TD + 22);
    esperar_ate(pst + TD + 60);
    soltar(0);

    // Two columns low on row 1 are rejected; scanning continues.
    esperar_ate(base_b);
    teclas[1] = 4'b0011;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      chk("varredura_fantasma", int'(linhas), int'(linha_esperada(gcyc)));
    end
    p2 = gcyc;
    teclas[1][0] = 1'b0;
    e1 = instante_strobe(1, p2);
    esperar(4'h5, e1, e1);
    esperar_ate(e1 + 20);
    soltar(1);

    // Second key while the first is held is ignored.
    esperar_ate(base_b);
    p = gcyc;
    teclas[3][0] = 1'b1;
    e1 = instante_strobe(3, p);
    esperar(4'hC, e1, e1);
    esperar_ate(e1 + 5);
    teclas[0][2] = 1'b1;
    esperar_ate(e1 + 45);
    chk("linha_segunda_tecla", int'(linhas), int'(LINHA3));
    soltar(3);
    esperar_ate(base_b + 7);
    p = gcyc;
    teclas[0][2] = 1'b1;
    e1 = instante_strobe(0, p);
    esperar(4'h2, e1, e1);
    esperar_ate(e1 + 20);
    soltar(0);

    // Reset during release wait, then during debounce at counter 10.
    esperar_ate(base_b);
    p = gcyc;
    teclas[2][1] = 1'b1;
    e1 = instante_strobe(2, p);
    esperar(4'h9, e1, e1);
    esperar_ate(e1 + 5);
    reset_n = 1'b0;
    #1;
    checa_reset("reset_solta");
    repeat (3) @(negedge clk);
    solta_reset();
    e2 = instante_strobe(2, gcyc);
    esperar_ate(e2 - TD - 1 + 11);
    reset_n = 1'b0;
    #1;
    checa_reset("reset_estabiliza");
    repeat (2) @(negedge clk);
    solta_reset();
    e2 = instante_strobe(2, gcyc);
    esperar(4'h9, e2, e2);
    esperar_ate(e2 + 10);
    soltar(2);

    // Randomised clean presses.
    for (int t = 0; t < 25; t++) begin
      esperar_ate(base_b + int'($urandom_range(0, 30)));
      r = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 3));
      r2 = r[1:0];
      c2 = c[1:0];
      teclas[r][c] = 1'b1;
      e1 = instante_strobe(r, gcyc);
      esperar({r2, c2}, e1, e1);
      esperar_ate(e1 + int'($urandom_range(2, 40)));
      soltar(r);
    end

    esperar_ate(gcyc + TD + 10);
    for (int k = 0; k < 200 && fila.size() != 0; k++) @(negedge clk);
    chk("fila_vazia", fila.size(), 0);
    chk("total_strobes", n_emitidos, n_esperados);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_erros);
    $finish;
  end

endmodule
